// File: rtl/cgra_cfg_pkg.sv
// Shared types and defaults for the CGRA configuration loader.
// Defaults match the configurator bitstream size.
package cgra_cfg_pkg;

  localparam int unsigned CFG_NUM_BITS     = 832;
  localparam int unsigned CFG_CNT_W        = 32;
  localparam int unsigned CFG_DONE_TIMEOUT = 8;
  localparam int unsigned STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    RESET_CFG,
    LOAD,
    WAIT_DONE,
    DONE,
    ERROR
  } cfg_state_e;

  function automatic logic busy_state(cfg_state_e s);
    return s inside {RESET_CFG, LOAD, WAIT_DONE};
  endfunction

endpackage

// File: rtl/cfg_skid_reg.sv
// One-entry, one-bit skid register for chain back-pressure.
// Load wins over drain; the loader never asks for both at once.
module cfg_skid_reg (
  input  logic clock,
  input  logic sync_reset_n,
  input  logic load,
  input  logic drain,
  input  logic load_bit,
  output logic valid,
  output logic data
);

  // capture a stalled bit, release it once the chain accepts it
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      valid <= 1'b0;
      data  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_bit;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cgra_config_loader.sv
// Streams the configurator bitstream into the CGRA scan chain.
// Handles chain hold via a skid entry and checks count vs. done.
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned NUM_BITS     = CFG_NUM_BITS,
  parameter int unsigned CNT_W        = CFG_CNT_W,
  parameter int unsigned DONE_TIMEOUT = CFG_DONE_TIMEOUT
) (
  input  logic             clock,
  input  logic             sync_reset_n,
  input  logic             start,
  input  logic             hold,
  output logic             cfg_enable_o,
  output logic             cfg_sync_reset,
  input  logic             cfg_bit_i,
  input  logic             cfg_done_i,
  output logic             chain_bit_o,
  output logic             chain_enable_o,
  output logic             busy,
  output logic             config_done,
  output logic             error,
  output logic [CNT_W-1:0] bits_shifted
);

  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] NB = CNT_W'(NUM_BITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

  if (64'(NUM_BITS) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("NUM_BITS does not fit in CNT_W bits");
  end

  if (DONE_TIMEOUT < 1) begin : g_bad_tmo
    $error("DONE_TIMEOUT must be at least 1");
  end

  cfg_state_e       state_q;
  cfg_state_e       state_d;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] shifted_q;
  logic [TMO_W-1:0] tmo_q;
  logic             in_valid_q;
  logic             skid_valid;
  logic             skid_data;
  logic             in_load;
  logic             in_move;
  logic             fwd_skid;
  logic             fwd_in;
  logic             skid_load;
  logic             skid_drain;

  assign in_load = (state_q == LOAD);
  assign in_move = (state_q == LOAD) || (state_q == WAIT_DONE);

  assign cfg_enable_o = in_load && !hold
                     && (issued_q < NB) && !skid_valid;

  assign fwd_skid   = in_move && !hold && skid_valid;
  assign fwd_in     = in_move && !hold && !skid_valid && in_valid_q;
  assign skid_load  = in_move && hold && in_valid_q;
  assign skid_drain = fwd_skid || (state_q == RESET_CFG);

  assign bits_shifted = shifted_q;

  cfg_skid_reg u_skid (
    .clock        (clock),
    .sync_reset_n (sync_reset_n),
    .load         (skid_load),
    .drain        (skid_drain),
    .load_bit     (cfg_bit_i),
    .valid        (skid_valid),
    .data         (skid_data)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RESET_CFG;
      end
      RESET_CFG: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (issued_q == NB) state_d = WAIT_DONE;
        else if (cfg_done_i) state_d = ERROR;
      end
      WAIT_DONE: begin
        if ((shifted_q == NB) && cfg_done_i) state_d = DONE;
        else if (tmo_q == TMO_LAST) state_d = ERROR;
      end
      DONE, ERROR: begin
        if (start) state_d = RESET_CFG;
      end
      default: state_d = IDLE;
    endcase
  end

  // status and configurator control outputs
  always_comb begin
    cfg_sync_reset = 1'b0;
    config_done    = 1'b0;
    error          = 1'b0;
    unique case (state_q)
      IDLE, RESET_CFG: cfg_sync_reset = 1'b1;
      DONE:            config_done    = 1'b1;
      ERROR:           error          = 1'b1;
      default: ;
    endcase
    busy = busy_state(state_q);
  end

  // counters, cleared on the way into a new load
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      issued_q  <= '0;
      shifted_q <= '0;
      tmo_q     <= '0;
    end else if (state_d == RESET_CFG) begin
      issued_q  <= '0;
      shifted_q <= '0;
      tmo_q     <= '0;
    end else begin
      if (cfg_enable_o) issued_q <= issued_q + CNT_W'(1);
      if (fwd_skid || fwd_in) shifted_q <= shifted_q + CNT_W'(1);
      if (state_q == WAIT_DONE) tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // arrival pipe and registered chain outputs
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      in_valid_q     <= 1'b0;
      chain_enable_o <= 1'b0;
      chain_bit_o    <= 1'b0;
    end else begin
      in_valid_q     <= cfg_enable_o;
      chain_enable_o <= fwd_skid || fwd_in;
      if (fwd_skid) chain_bit_o <= skid_data;
      else if (fwd_in) chain_bit_o <= cfg_bit_i;
    end
  end

endmodule
